// File: rtl/step_counter_pkg.sv
// Shared encodings and helpers for the step_counter event/address counter.
package step_counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

   // All-ones value of a count of the given width (1..32).
   function automatic logic [31:0] max_val(input int width);
      logic [32:0] one_hot;
      one_hot = 33'd1 << width;
      return 32'(one_hot - 33'd1);
   endfunction

endpackage

// File: rtl/step_counter_nbit_addsub.sv
// nbit_addsub: combinational WIDTH-bit add/subtract with carry (add) or borrow (subtract) out.
module nbit_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   result;

   // Subtract as a + ~b + 1; the raw carry-out is then the inverse of the borrow.
   assign b_eff  = b ^ {WIDTH{sub}};
   assign result = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   assign sum    = result[WIDTH-1:0];
   assign cout   = result[WIDTH] ^ sub;

endmodule

// File: rtl/step_counter.sv
// Registered up/down step counter with wrap or saturate, carry pulse and sticky status.
// Optional prescaler enabled by defining STEP_COUNTER_PRESCALE_EN.
module step_counter
   import step_counter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
`ifdef STEP_COUNTER_PRESCALE_EN
   ,
   parameter int PRESCALE = 4
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              dir,
   input  logic [STEP_W-1:0] step,
   input  logic              mode,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              stat_clr,
   output logic [WIDTH-1:0]  count,
   output logic              carry,
   output logic              stat,
   output logic              at_limit
);

   generate
      if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
         $fatal(1, "step_counter: WIDTH must be in 2..32");
      end
      if (STEP_W < 1 || STEP_W > WIDTH) begin : g_bad_step_w
         $fatal(1, "step_counter: STEP_W must be in 1..WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(max_val(WIDTH));

   logic [WIDTH-1:0] count_reg, count_next;
   logic             carry_reg, carry_next;
   logic             stat_reg, stat_next;
   logic [WIDTH-1:0] step_ext;
   logic [WIDTH-1:0] sum;
   logic             ovf;
   logic             advance;

   assign step_ext = WIDTH'(step);

   nbit_addsub #(
      .WIDTH(WIDTH)
   ) u_addsub (
      .a    (count_reg),
      .b    (step_ext),
      .sub  (dir == DIR_DOWN),
      .sum  (sum),
      .cout (ovf)
   );

`ifdef STEP_COUNTER_PRESCALE_EN
   generate
      if (PRESCALE < 1) begin : g_bad_prescale
         $fatal(1, "step_counter: PRESCALE must be >= 1");
      end
   endgenerate

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0] pre_reg, pre_next;
   logic             tick;

   // Only enabled cycles move the prescaler; a load restarts the spacing.
   assign tick = (pre_reg == PRE_W'(PRESCALE - 1));

   always_comb begin
      pre_next = pre_reg;
      if (load) begin
         pre_next = '0;
      end else if (en) begin
         pre_next = tick ? '0 : pre_reg + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_reg <= '0;
      end else begin
         pre_reg <= pre_next;
      end
   end

   assign advance = en && !load && tick;
`else
   assign advance = en && !load;
`endif

   always_comb begin
      count_next = count_reg;
      carry_next = 1'b0;
      stat_next  = stat_reg;
      if (stat_clr) begin
         stat_next = 1'b0;
      end
      if (load) begin
         count_next = load_val;
      end else if (advance) begin
         carry_next = ovf;
         count_next = sum;
         // A new overflow outranks a simultaneous stat_clr.
         if (ovf) begin
            stat_next = 1'b1;
            if (mode == MODE_SAT) begin
               count_next = (dir == DIR_DOWN) ? '0 : ALL_ONES;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
         carry_reg <= 1'b0;
         stat_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         carry_reg <= carry_next;
         stat_reg  <= stat_next;
      end
   end

   assign count    = count_reg;
   assign carry    = carry_reg;
   assign stat     = stat_reg;
   assign at_limit = (dir == DIR_UP) ? (count_reg == ALL_ONES) : (count_reg == '0);

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter (default build): directed steps then random cycles vs. a reference model.
module tb_step_counter;

   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;
   localparam int MAXV   = (1 << WIDTH) - 1;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b1;
   logic              en       = 1'b0;
   logic              dir      = 1'b0;
   logic [STEP_W-1:0] step     = '0;
   logic              mode     = 1'b0;
   logic              load     = 1'b0;
   logic [WIDTH-1:0]  load_val = '0;
   logic              stat_clr = 1'b0;
   logic [WIDTH-1:0]  count;
   logic              carry;
   logic              stat;
   logic              at_limit;

   int checks = 0;
   int passed = 0;

   // Reference state: count as a plain integer, flags as bits.
   int m_count = 0;
   bit m_carry = 1'b0;
   bit m_stat  = 1'b0;

   step_counter #(
      .WIDTH (WIDTH),
      .STEP_W(STEP_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .dir     (dir),
      .step    (step),
      .mode    (mode),
      .load    (load),
      .load_val(load_val),
      .stat_clr(stat_clr),
      .count   (count),
      .carry   (carry),
      .stat    (stat),
      .at_limit(at_limit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Arithmetic model of one clock edge from the current inputs.
   task automatic model_edge();
      int r;
      bit ovf;
      ovf = 1'b0;
      if (load) begin
         m_count = int'(load_val);
         m_carry = 1'b0;
      end else if (en) begin
         r   = dir ? m_count - int'(step) : m_count + int'(step);
         ovf = (r < 0) || (r > MAXV);
         if (!ovf)      m_count = r;
         else if (mode) m_count = dir ? 0 : MAXV;
         else           m_count = (r + MAXV + 1) % (MAXV + 1);
         m_carry = ovf;
      end else begin
         m_carry = 1'b0;
      end
      if (ovf)           m_stat = 1'b1;
      else if (stat_clr) m_stat = 1'b0;
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, ".count"}, 32'(count), 32'(m_count));
      check({tag, ".carry"}, 32'(carry), 32'(m_carry));
      check({tag, ".stat"}, 32'(stat), 32'(m_stat));
      check({tag, ".at_limit"}, 32'(at_limit),
            32'(dir ? (m_count == 0) : (m_count == MAXV)));
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check("reset.count", 32'(count), 32'h0);
      check("reset.carry", 32'(carry), 32'h0);
      check("reset.stat", 32'(stat), 32'h0);
      #10 rst_n = 1'b1;

      // Set stat, then load 0x5A and reset in the middle of a cycle.
      load = 1'b1; load_val = 8'hFF;           tick("pre_load_ff");
      load = 1'b0; en = 1'b1; step = 4'd1;    tick("pre_wrap");
      en = 1'b0; load = 1'b1; load_val = 8'h5A; tick("pre_load_5a");
      load = 1'b0;
      check("pre_reset.count", 32'(count), 32'h5A);
      check("pre_reset.stat", 32'(stat), 32'h1);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset.count", 32'(count), 32'h0);
      check("async_reset.carry", 32'(carry), 32'h0);
      check("async_reset.stat", 32'(stat), 32'h0);
      m_count = 0; m_carry = 1'b0; m_stat = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick("idle");
      check("idle.count", 32'(count), 32'h0);

      // Wrap up.
      load = 1'b1; load_val = 8'hFE;           tick("wrap_load");
      load = 1'b0; en = 1'b1; dir = 1'b0; step = 4'd3; mode = 1'b0;
      tick("wrap_up");
      check("wrap_up.count_const", 32'(count), 32'h01);
      check("wrap_up.carry_const", 32'(carry), 32'h1);
      step = 4'd1;                             tick("wrap_next");
      check("wrap_next.count_const", 32'(count), 32'h02);
      check("wrap_next.carry_const", 32'(carry), 32'h0);

      // Saturate down, twice.
      en = 1'b0; load = 1'b1; load_val = 8'h02; tick("sat_load");
      load = 1'b0; en = 1'b1; dir = 1'b1; step = 4'd5; mode = 1'b1;
      tick("sat_down1");
      check("sat_down1.count_const", 32'(count), 32'h00);
      check("sat_down1.carry_const", 32'(carry), 32'h1);
      tick("sat_down2");
      check("sat_down2.carry_const", 32'(carry), 32'h1);

      // Priority: load beats advance; overflow beats stat_clr.
      load = 1'b1; load_val = 8'h40; dir = 1'b0; step = 4'd7; tick("prio_load");
      check("prio_load.count_const", 32'(count), 32'h40);
      load_val = 8'hFE;                        tick("prio_load_fe");
      load = 1'b0; mode = 1'b0; stat_clr = 1'b1; tick("prio_ovf_clr");
      check("prio_ovf_clr.stat_const", 32'(stat), 32'h1);
      en = 1'b0;                               tick("prio_clr");
      check("prio_clr.stat_const", 32'(stat), 32'h0);
      stat_clr = 1'b0;

      // step=0 at the top limit, then flip direction.
      load = 1'b1; load_val = 8'hFF;           tick("zero_load");
      load = 1'b0; en = 1'b1; dir = 1'b0; step = 4'd0; tick("zero_step");
      check("zero_step.count_const", 32'(count), 32'hFF);
      check("zero_step.at_limit_const", 32'(at_limit), 32'h1);
      dir = 1'b1;
      #1;
      check("dir_flip.at_limit_const", 32'(at_limit), 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         en       = ($urandom_range(0, 9) < 7);
         dir      = 1'($urandom_range(0, 1));
         mode     = 1'($urandom_range(0, 1));
         step     = STEP_W'($urandom_range(0, 15));
         load     = ($urandom_range(0, 9) == 0);
         load_val = WIDTH'($urandom_range(0, 255));
         stat_clr = ($urandom_range(0, 4) == 0);
         tick("rand");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
